muldiv: RTL

MULDIV -- requirements
Module: muldiv

---
 rtl/muldiv.sv | 127 ++++++++++++
 1 files changed

// File: rtl/muldiv.sv
// Iterative 32-bit unsigned multiplier/divider: radix-2 shift-add MUL/MULHU, restoring DIVU/REMU.
// Define MULDIV_DIV_EN to build the divider; without it DIVU/REMU complete in one cycle with zero.
module muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        muldiv__req,
  input  logic [1:0]  muldiv__op,
  input  logic [31:0] muldiv__left,
  input  logic [31:0] muldiv__right,
  output logic        muldiv__busy,
  output logic        muldiv__done,
  output logic [31:0] muldiv__out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [4:0]  count;
  logic        hi_sel;
  logic [31:0] a_q;
  logic [32:0] acc_hi;
  logic [31:0] acc_lo;
  logic        accept;
  logic        skip_run;
  logic        last_iter;
  logic [32:0] mul_sum;
  logic [32:0] step_hi;
  logic [31:0] step_lo;
  logic [31:0] result;

`ifdef MULDIV_DIV_EN
  logic        is_div;
  logic [31:0] b_q;
  logic [32:0] rem_shift;
  logic [33:0] div_diff;
`endif

  assign accept    = muldiv__req && (state != RUN);
  assign last_iter = (count == 5'd31);

`ifdef MULDIV_DIV_EN
  assign skip_run = 1'b0;
`else
  assign skip_run = muldiv__op[1];
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (muldiv__req) next_state = skip_run ? DONE : RUN;
        else             next_state = IDLE;
      end
      RUN: begin
        if (last_iter) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // One iteration: acc_hi holds the running high product (or partial remainder),
  // acc_lo the shifting multiplier (or dividend bits becoming quotient bits).
  always_comb begin
    mul_sum = acc_hi + (acc_lo[0] ? {1'b0, a_q} : 33'd0);
    step_hi = {1'b0, mul_sum[32:1]};
    step_lo = {mul_sum[0], acc_lo[31:1]};
`ifdef MULDIV_DIV_EN
    rem_shift = {acc_hi[31:0], acc_lo[31]};
    div_diff  = {1'b0, rem_shift} - {2'b00, b_q};
    if (is_div) begin
      if (div_diff[33]) begin
        step_hi = rem_shift;
        step_lo = {acc_lo[30:0], 1'b0};
      end else begin
        step_hi = div_diff[32:0];
        step_lo = {acc_lo[30:0], 1'b1};
      end
    end
`endif
    // MULHU and REMU both live in the high half; MUL and DIVU in the low half
    result = hi_sel ? step_hi[31:0] : step_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= 5'd0;
      hi_sel      <= 1'b0;
      a_q         <= 32'd0;
      acc_hi      <= 33'd0;
      acc_lo      <= 32'd0;
      muldiv__out <= 32'd0;
`ifdef MULDIV_DIV_EN
      is_div      <= 1'b0;
      b_q         <= 32'd0;
`endif
    end else begin
      state <= next_state;
      if (accept) begin
        hi_sel <= muldiv__op[0];
        a_q    <= muldiv__left;
        acc_hi <= 33'd0;
        acc_lo <= muldiv__op[1] ? muldiv__left : muldiv__right;
        count  <= 5'd0;
`ifdef MULDIV_DIV_EN
        is_div <= muldiv__op[1];
        b_q    <= muldiv__right;
`endif
        if (skip_run) muldiv__out <= 32'd0;
      end else if (state == RUN) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        count  <= count + 5'd1;
        if (last_iter) muldiv__out <= result;
      end
    end
  end

  assign muldiv__busy = (state == RUN);
  assign muldiv__done = (state == DONE);

endmodule
